mul_rr_scheduler: RTL and testbench
===================================

# mul_rr_scheduler

Round-robin scheduler that shares one combinational 4x4 Wallace-tree multiplier among NREQ requesters. It arbitrates incoming operand requests and drives registered operands into the shared multiplier. It then captures the product and returns it, tagged with the requester ID, over a valid/ready response channel. It sits between the client ports and the multiplier instance; the multiplier itself is unchanged and instantiated beside this block.

## Interface
- NREQ, 4, number of requesters (legal 2..8); IDW = max(1, clog2(NREQ)) localparam
- W, 4, operand width; must match the multiplier (product width 2W)

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  request i pending
- req_a  in  NREQ*W  operand A of requester i at [i*W +: W]
- req_b  in  NREQ*W  operand B of requester i at [i*W +: W]
- req_ready  out  NREQ  one-hot grant; handshake on req_valid[i] & req_ready[i]
- mul_a  out  W  registered operand A to the shared multiplier
- mul_b  out  W  registered operand B to the shared multiplier
- mul_p  in  2W  multiplier product (combinational from mul_a/mul_b)
- rsp_valid  out  1  response available
- rsp_id  out  IDW  index of the requester that owns the response
- rsp_product  out  2W  registered product
- rsp_ready  in  1  response consumer accepts

## Operation
- FSM states: IDLE, CALC, RESP.
- **IDLE:**
  - If any req_valid, compute grant g = first set bit scanning last_id+1, last_id+2, … modulo NREQ.
  - Assert req_ready[g] only; all other req_ready bits stay 0.
  - On that edge: mul_a <= req_a[g], mul_b <= req_b[g], cur_id <= g, last_id <= g, state -> CALC.
  - No req_valid: remain in IDLE; req_ready = 0.
- **CALC:** one cycle with the multiplier settling. On the edge: rsp_product <= mul_p, rsp_id <= cur_id, rsp_valid <= 1, state -> RESP.
- **RESP:** hold rsp_valid, rsp_id and rsp_product stable until rsp_valid & rsp_ready. On that edge: rsp_valid <= 0, state -> IDLE.
- req_ready is 0 in CALC and RESP, and while rst is high.
- req_ready is combinational from req_valid, state and last_id. Requesters must not derive req_valid from req_ready. A requester holds req_valid, req_a and req_b stable until its handshake.
- mul_a and mul_b change only on a grant edge and hold their last operands otherwise (no toggling of the tree while idle).
- **Arithmetic:** unsigned; product 2W bits, no truncation (15*15 = 225 for W=4).
- **Wrap-around:** last_id = NREQ-1 scans from 0. Pointer advances only on a grant, never on idle cycles.
- **Reset values** (asynchronous, any state):
  - state IDLE, last_id NREQ-1
  - cur_id 0, mul_a 0, mul_b 0
  - rsp_valid 0, rsp_id 0, rsp_product 0
- **Reset mid-operation:** any in-flight or unaccepted response is discarded. No rsp_valid pulse follows reset.

## Timing
- Grant handshake on edge T. mul_a/mul_b valid in cycle T+1 (CALC).
- rsp_valid high from cycle T+2; accept-to-response latency is 2 cycles.
- Response accepted on edge R. IDLE in cycle R+1; earliest next grant handshake on edge R+1.
- Peak throughput: one product per 3 cycles with rsp_ready held high.
- No simultaneous grant and response: the FSM serialises them by construction.
- Critical path: mul_a/mul_b registers -> multiplier -> rsp_product register, a full cycle.

## Test plan
- **Reset:** assert rst with req_valid = 4'b1111 -> req_ready = 0, rsp_valid = 0, mul_a = mul_b = 0. Release -> first grant to requester 0.
- **Single request:** req_valid[2] = 1, a = 3, b = 5 -> req_ready = 4'b0100 the same cycle; rsp_valid 2 cycles later with rsp_id = 2 and rsp_product = 15.
- **Full load:** all four requesters valid, operands (1,2), (15,15), (7,9), (0,13), rsp_ready = 1 -> grants in order 0,1,2,3,0. Responses are 2, 225, 63, 0, each 3 cycles apart.
- **Backpressure:** hold rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_id/rsp_product stable and req_ready = 0 throughout. Raise rsp_ready -> next grant on the following edge.
- **Wrap-around:** after a grant to 3, requesters 0 and 3 valid -> grant 0. Next, only 3 valid -> grant 3.
- **Reset in CALC:** pulse rst during CALC -> rsp_valid stays 0 and last_id returns to 3. The next request from requesters 1 and 0 grants 0 first.

Source files
------------

// File: rtl/mul_rr_scheduler.sv
// -----------------------------------------------------------------------------
// mul_rr_scheduler
//
// Shares one combinational WxW multiplier among NREQ requesters. A round-robin
// arbiter picks one pending request and drives its operands into registered
// multiplier inputs. One cycle later it captures the product. The product is
// then returned with the requester ID over a valid/ready response channel.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   req_valid    [NREQ]     request i pending
//   req_a/req_b  [NREQ*W]   operands of requester i at [i*W +: W]
//   req_ready    [NREQ]     one-hot grant (combinational, IDLE only)
//   mul_a/mul_b  [W]        registered operands to the shared multiplier
//   mul_p        [2W]       product from the shared multiplier
//   rsp_valid    response available
//   rsp_id       [IDW]      owner of the response
//   rsp_product  [2W]       registered product
//   rsp_ready    response consumer accepts
// -----------------------------------------------------------------------------
module mul_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [2*W-1:0]    mul_p,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [2*W-1:0]    rsp_product,
    input  logic              rsp_ready
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_id_q, last_id_d;
    logic [IDW-1:0]   cur_id_q, cur_id_d;
    logic [W-1:0]     mul_a_q, mul_a_d;
    logic [W-1:0]     mul_b_q, mul_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [2*W-1:0]   rsp_product_q, rsp_product_d;

    logic             found;
    logic [IDW-1:0]   grant_id;
    logic [IDW:0]     idx;
    logic             grant_en;

    // Round-robin search: scan last_id+1 .. last_id+NREQ modulo NREQ and take
    // the first pending requester. idx has one spare bit so the sum cannot
    // overflow before the modulo correction.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        idx      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = {1'b0, last_id_q} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) begin
                idx = idx - (IDW+1)'(NREQ);
            end
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found    = 1'b1;
                grant_id = idx[IDW-1:0];
            end
        end
    end

    // Grant is visible only in IDLE and never while reset is held.
    assign grant_en = (state_q == IDLE) && found && !rst;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_en && (grant_id == IDW'(gi));
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        last_id_d     = last_id_q;
        cur_id_d      = cur_id_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_product_d = rsp_product_q;
        case (state_q)
            IDLE: begin
                // Operand registers load only on a grant so the multiplier
                // tree stays quiet while idle.
                if (found) begin
                    mul_a_d   = req_a[grant_id*W +: W];
                    mul_b_d   = req_b[grant_id*W +: W];
                    cur_id_d  = grant_id;
                    last_id_d = grant_id;
                    state_d   = CALC;
                end
            end
            CALC: begin
                rsp_product_d = mul_p;
                rsp_id_d      = cur_id_q;
                rsp_valid_d   = 1'b1;
                state_d       = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_id_q     <= IDW'(NREQ-1);
            cur_id_q      <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_product_q <= '0;
        end else begin
            state_q       <= state_d;
            last_id_q     <= last_id_d;
            cur_id_q      <= cur_id_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_product_q <= rsp_product_d;
        end
    end

    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_product = rsp_product_q;

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mul_rr_scheduler
//
// Directed bench for mul_rr_scheduler (NREQ=4, W=4). A table of transactions
// checks grant order and products. Hand-written sequences then cover reset,
// backpressure in RESP and reset during CALC. The shared multiplier is modelled
// here as a plain combinational product.
// -----------------------------------------------------------------------------
module tb_mul_rr_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [2*W-1:0]    mul_p;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [2*W-1:0]    rsp_product;
    logic              rsp_ready;

    mul_rr_scheduler #(.NREQ(NREQ), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_p       (mul_p),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .rsp_ready   (rsp_ready)
    );

    // Stand-in for the shared multiplier beside the scheduler.
    assign mul_p = (2*W)'(mul_a) * (2*W)'(mul_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]   valid;
        logic [NREQ*W-1:0] a;
        logic [NREQ*W-1:0] b;
        int                grant;
        logic [2*W-1:0]    prod;
    } vec_t;

    vec_t tbl [11];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Entered just after a rising edge with the DUT in IDLE; leaves just after
    // the edge that accepts the response, i.e. in the next IDLE cycle.
    task automatic run_txn(input vec_t v, input int n);
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        ea = v.a[v.grant*W +: W];
        eb = v.b[v.grant*W +: W];
        req_valid = v.valid;
        req_a     = v.a;
        req_b     = v.b;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("grant", 16'(req_ready), 16'(4'(1) << v.grant));
        chk("idle_rsp_valid", 16'(rsp_valid), 16'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("calc_ready", 16'(req_ready), 16'd0);
        chk("calc_mul_a", 16'(mul_a), 16'(ea));
        chk("calc_mul_b", 16'(mul_b), 16'(eb));
        chk("calc_rsp_valid", 16'(rsp_valid), 16'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("resp_valid", 16'(rsp_valid), 16'd1);
        chk("resp_id", 16'(rsp_id), 16'(v.grant));
        chk("resp_product", 16'(rsp_product), 16'(v.prod));
        chk("resp_ready", 16'(req_ready), 16'd0);
        $display("txn %0d: valid=%b grant=%0d id=%0d product=%0d", n, v.valid, v.grant, rsp_id, rsp_product);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t v;

        // Full load (grants 0,1,2,3,0), then single request, wrap-around.
        tbl[0]  = '{4'b1111, 16'h07F1, 16'hD9F2, 0, 8'd2};
        tbl[1]  = '{4'b1111, 16'h07F1, 16'hD9F2, 1, 8'd225};
        tbl[2]  = '{4'b1111, 16'h07F1, 16'hD9F2, 2, 8'd63};
        tbl[3]  = '{4'b1111, 16'h07F1, 16'hD9F2, 3, 8'd0};
        tbl[4]  = '{4'b1111, 16'h07F1, 16'hD9F2, 0, 8'd2};
        tbl[5]  = '{4'b0100, 16'h0300, 16'h0500, 2, 8'd15};
        tbl[6]  = '{4'b1000, 16'h6000, 16'hB000, 3, 8'd66};
        tbl[7]  = '{4'b1001, 16'h1009, 16'h1004, 0, 8'd36};
        tbl[8]  = '{4'b1000, 16'hE000, 16'h3000, 3, 8'd42};
        tbl[9]  = '{4'b0011, 16'h002F, 16'h0081, 0, 8'd15};
        tbl[10] = '{4'b0011, 16'h002F, 16'h0081, 1, 8'd16};

        // Reset held with all requesters pending.
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = 16'h07F1;
        req_b     = 16'hD9F2;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 16'(req_ready), 16'd0);
        chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        chk("rst_mul_a", 16'(mul_a), 16'd0);
        chk("rst_mul_b", 16'(mul_b), 16'd0);
        chk("rst_rsp_id", 16'(rsp_id), 16'd0);
        chk("rst_rsp_product", 16'(rsp_product), 16'd0);
        $display("txn reset: ready=%b rsp_valid=%b", req_ready, rsp_valid);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_txn(tbl[i], i);
        end

        // Backpressure: requester 2 granted, response held 5 cycles while
        // requester 1 waits; requester 1 is granted on the edge after accept.
        req_valid = 4'b0110;
        req_a     = 16'h0D50;
        req_b     = 16'h0C50;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_grant", 16'(req_ready), 16'b0100);
        @(posedge clk); #1;
        req_valid = 4'b0010;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid", 16'(rsp_valid), 16'd1);
            chk("bp_id", 16'(rsp_id), 16'd2);
            chk("bp_product", 16'(rsp_product), 16'd156);
            chk("bp_ready", 16'(req_ready), 16'd0);
            $display("txn bp cycle %0d: rsp_valid=%b id=%0d product=%0d", c, rsp_valid, rsp_id, rsp_product);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 16'(rsp_valid), 16'd1);
        @(posedge clk); #1;
        v = '{4'b0010, 16'h0D50, 16'h0C50, 1, 8'd25};
        run_txn(v, 11);

        // Reset during CALC: the in-flight product is discarded and the
        // pointer returns to NREQ-1.
        req_valid = 4'b0100;
        req_a     = 16'h0A00;
        req_b     = 16'h0A00;
        @(negedge clk);
        chk("rc_grant", 16'(req_ready), 16'b0100);
        @(posedge clk); #1;
        rst       = 1'b1;
        req_valid = 4'b0000;
        #2;
        chk("rc_rst_valid", 16'(rsp_valid), 16'd0);
        chk("rc_rst_mul_a", 16'(mul_a), 16'd0);
        chk("rc_rst_ready", 16'(req_ready), 16'd0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rc_no_pulse", 16'(rsp_valid), 16'd0);
            @(posedge clk); #1;
        end
        $display("txn reset-in-calc: rsp_valid=%b", rsp_valid);
        v = '{4'b0011, 16'h0034, 16'h0074, 0, 8'd16};
        run_txn(v, 12);
        v = '{4'b0011, 16'h0034, 16'h0074, 1, 8'd21};
        run_txn(v, 13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
